// File: rtl/noc_pkg.sv
// Shared NoC network-interface types: flit layout and TX FSM state encoding.
package noc_pkg;

  localparam int unsigned FLIT_W  = 16;
  localparam int unsigned COORD_W = 4;

  typedef struct packed {
    logic [7:0]         payload;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
  } flit_t;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitCredit
  } tx_state_t;

endpackage

// File: rtl/ni_fifo.sv
// Synchronous FIFO with wrapping pointers and occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ni_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/net_iface.sv
// Network interface between a host and a router local port, credit-based TX, FIFO RX.
// Define NET_IFACE_STATS_EN to build the TX/RX statistics counters.
module net_iface
  import noc_pkg::*;
#(
  parameter int unsigned XCOORD   = 4'd0,
  parameter int unsigned YCOORD   = 4'd0,
  parameter int unsigned CREDITS  = 4,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_dest,
  input  logic [7:0]  tx_payload,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [15:0] rx_data,
  output logic [15:0] net_data_o,
  output logic        net_valid_o,
  input  logic        net_credit_i,
  input  logic [15:0] net_data_i,
  input  logic        net_valid_i,
  output logic        net_credit_o,
  output logic [1:0]  err_o,
  output logic [15:0] tx_count_o,
  output logic [15:0] rx_count_o
);

  localparam int unsigned CredW  = $clog2(CREDITS + 1);
  localparam int unsigned TxCntW = $clog2(TX_DEPTH + 1);
  localparam int unsigned RxCntW = $clog2(RX_DEPTH + 1);

  // Node id is reserved for a source field; the current flit format carries none.
  localparam logic [2*COORD_W-1:0] unused_src_id = {COORD_W'(XCOORD), COORD_W'(YCOORD)};

  flit_t             tx_wflit, tx_head;
  logic              tx_full, tx_empty, tx_push, tx_send;
  logic [TxCntW-1:0] tx_occ, tx_occ_next;
  tx_state_t         state_q, state_d;
  logic [CredW-1:0]  credit_q, credit_d;
  logic              credit_ovf;

  logic              rx_full, rx_empty, rx_pop, rx_accept, rx_drop;
  logic [RxCntW-1:0] unused_rx_occ;

  assign tx_wflit = '{payload: tx_payload, dest_x: tx_dest[7:4], dest_y: tx_dest[3:0]};
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && tx_ready;
  assign tx_send  = (state_q == StSend);

  ni_fifo #(
    .Width(FLIT_W),
    .Depth(TX_DEPTH)
  ) u_tx_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (tx_push),
    .wdata_i(tx_wflit),
    .pop_i  (tx_send),
    .rdata_o(tx_head),
    .full_o (tx_full),
    .empty_o(tx_empty),
    .count_o(tx_occ)
  );

  assign rx_valid  = !rx_empty;
  assign rx_pop    = rx_valid && rx_ready;
  assign rx_accept = net_valid_i && (!rx_full || rx_pop);
  assign rx_drop   = net_valid_i && !rx_accept;

  ni_fifo #(
    .Width(FLIT_W),
    .Depth(RX_DEPTH)
  ) u_rx_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (net_valid_i),
    .wdata_i(net_data_i),
    .pop_i  (rx_ready),
    .rdata_o(rx_data),
    .full_o (rx_full),
    .empty_o(rx_empty),
    .count_o(unused_rx_occ)
  );

  // State is derived from next-cycle occupancy and credit so StSend always implies a send.
  assign tx_occ_next = tx_occ + TxCntW'(tx_push) - TxCntW'(tx_send);

  always_comb begin
    credit_d   = credit_q;
    credit_ovf = 1'b0;
    case ({net_credit_i, tx_send})
      2'b10: begin
        if (credit_q == CredW'(CREDITS)) credit_ovf = 1'b1;
        else                             credit_d   = credit_q + 1'b1;
      end
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase

    if (tx_occ_next == '0)     state_d = StIdle;
    else if (credit_d == '0)   state_d = StWaitCredit;
    else                       state_d = StSend;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      credit_q     <= CredW'(CREDITS);
      net_valid_o  <= 1'b0;
      net_data_o   <= '0;
      net_credit_o <= 1'b0;
      err_o        <= '0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      net_valid_o  <= tx_send;
      net_credit_o <= rx_pop;
      if (tx_send)    net_data_o <= tx_head;
      if (credit_ovf) err_o[0]   <= 1'b1;
      if (rx_drop)    err_o[1]   <= 1'b1;
    end
  end

`ifdef NET_IFACE_STATS_EN
  logic [15:0] tx_count_q, rx_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_count_q <= '0;
      rx_count_q <= '0;
    end else begin
      if (tx_send)   tx_count_q <= tx_count_q + 16'd1;
      if (rx_accept) rx_count_q <= rx_count_q + 16'd1;
    end
  end

  assign tx_count_o = tx_count_q;
  assign rx_count_o = rx_count_q;
`else
  assign tx_count_o = '0;
  assign rx_count_o = '0;
`endif

endmodule

// File: tb/tb_net_iface.sv
// Directed self-checking bench for net_iface: TX credit flow, RX overflow, reset, statistics.
module tb_net_iface;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  tx_dest = '0;
  logic [7:0]  tx_payload = '0;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [15:0] rx_data;
  logic [15:0] net_data_o;
  logic        net_valid_o;
  logic        net_credit_i = 1'b0;
  logic [15:0] net_data_i = '0;
  logic        net_valid_i = 1'b0;
  logic        net_credit_o;
  logic [1:0]  err_o;
  logic [15:0] tx_count_o;
  logic [15:0] rx_count_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int credit_pulses = 0;
  logic [15:0] sent_q [$];
  int          sent_cyc [$];

  net_iface dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_dest     (tx_dest),
    .tx_payload  (tx_payload),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .net_data_o  (net_data_o),
    .net_valid_o (net_valid_o),
    .net_credit_i(net_credit_i),
    .net_data_i  (net_data_i),
    .net_valid_i (net_valid_i),
    .net_credit_o(net_credit_o),
    .err_o       (err_o),
    .tx_count_o  (tx_count_o),
    .rx_count_o  (rx_count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (net_valid_o) begin
      sent_q.push_back(net_data_o);
      sent_cyc.push_back(cyc);
    end
    if (net_credit_o) credit_pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic credit_pulse(input int n);
    net_credit_i = 1'b1;
    tick(n);
    net_credit_i = 1'b0;
  endtask

  task automatic clear_sent();
    sent_q.delete();
    sent_cyc.delete();
  endtask

  initial begin
    int push_cyc;
    int c;
    int n_sent;

    // Reset state
    tick(2);
    check_eq("rst_tx_ready", 32'(tx_ready), 1);
    check_eq("rst_rx_valid", 32'(rx_valid), 0);
    check_eq("rst_net_valid", 32'(net_valid_o), 0);
    check_eq("rst_net_credit", 32'(net_credit_o), 0);
    check_eq("rst_err", 32'(err_o), 0);
    check_eq("rst_net_data", 32'(net_data_o), 0);
    check_eq("rst_credit", 32'(dut.credit_q), 4);
    check_eq("rst_tx_count", 32'(tx_count_o), 0);
    check_eq("rst_rx_count", 32'(rx_count_o), 0);
    rst = 1'b1;
    tick(1);
    clear_sent();

    // Three back-to-back flits to 8'h21
    push_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1;
      tx_dest = 8'h21;
      tx_payload = 8'(8'hA0 + i);
      tick(1);
      if (i == 0) push_cyc = cyc;
    end
    tx_valid = 1'b0;
    tick(3);
    check_eq("burst_count", 32'(sent_q.size()), 3);
    if (sent_q.size() == 3) begin
      check_eq("burst_flit0", 32'(sent_q[0]), 'hA021);
      check_eq("burst_flit1", 32'(sent_q[1]), 'hA121);
      check_eq("burst_flit2", 32'(sent_q[2]), 'hA221);
      check_eq("burst_latency", 32'(sent_cyc[0] - push_cyc), 1);
      check_eq("burst_consecutive", 32'(sent_cyc[2] - sent_cyc[0]), 2);
    end
    check_eq("burst_credit", 32'(dut.credit_q), 1);
    check_eq("hold_net_data", 32'(net_data_o), 'hA221);
    clear_sent();

    // Credit return in the same cycle as a send at credit=1
    tx_valid = 1'b1;
    tx_dest = 8'h12;
    tx_payload = 8'hB0;
    tick(1);
    tx_payload = 8'hB1;
    net_credit_i = 1'b1;
    tick(1);
    check_eq("same_cycle_credit", 32'(dut.credit_q), 1);
    tx_valid = 1'b0;
    net_credit_i = 1'b0;
    tick(3);
    check_eq("nostall_count", 32'(sent_q.size()), 2);
    if (sent_q.size() == 2) begin
      check_eq("nostall_flit1", 32'(sent_q[1]), 'hB112);
      check_eq("nostall_consecutive", 32'(sent_cyc[1] - sent_cyc[0]), 1);
    end
    check_eq("nostall_credit", 32'(dut.credit_q), 0);
    credit_pulse(4);
    tick(1);
    check_eq("credit_restored", 32'(dut.credit_q), 4);

    // Credit overflow saturates and sets err_o[0]
    credit_pulse(1);
    tick(1);
    check_eq("credit_sat", 32'(dut.credit_q), 4);
    check_eq("credit_ovf_err", 32'(err_o), 'b01);
    clear_sent();

    // Six flits, no credit return: four leave, two wait
    for (int i = 0; i < 6; i++) begin
      tx_valid = 1'b1;
      tx_dest = 8'h35;
      tx_payload = 8'(8'hC0 + i);
      tick(1);
    end
    tx_valid = 1'b0;
    tick(3);
    check_eq("starve_sent", 32'(sent_q.size()), 4);
    if (sent_q.size() == 4) check_eq("starve_flit3", 32'(sent_q[3]), 'hC335);
    check_eq("starve_state", 32'(dut.state_q), 32'(StWaitCredit));
    check_eq("starve_queued", 32'(dut.u_tx_fifo.count_o), 2);
    check_eq("starve_credit", 32'(dut.credit_q), 0);
    credit_pulse(1);
    c = cyc;
    tick(3);
    check_eq("resume_sent", 32'(sent_q.size()), 5);
    if (sent_q.size() == 5) begin
      check_eq("resume_flit", 32'(sent_q[4]), 'hC435);
      check_eq("resume_latency", 32'(sent_cyc[4] - c), 1);
    end
    credit_pulse(5);
    tick(2);
    check_eq("drain_sent", 32'(sent_q.size()), 6);
    check_eq("drain_credit", 32'(dut.credit_q), 4);

    // RX: five writes into a four-deep FIFO with no pops
    for (int i = 0; i < 5; i++) begin
      net_valid_i = 1'b1;
      net_data_i = 16'(16'hD000 + i);
      tick(1);
    end
    net_valid_i = 1'b0;
    tick(1);
    check_eq("rx_full_valid", 32'(rx_valid), 1);
    check_eq("rx_ovf_err", 32'(err_o), 'b11);
    check_eq("rx_head", 32'(rx_data), 'hD000);
    check_eq("rx_no_credit", 32'(credit_pulses), 0);

    // Four pops; the first coincides with a write into the full FIFO
    rx_ready = 1'b1;
    net_valid_i = 1'b1;
    net_data_i = 16'hD005;
    for (int i = 0; i < 4; i++) begin
      check_eq("rx_pop_data", 32'(rx_data), 32'(16'hD000 + i));
      tick(1);
      net_valid_i = 1'b0;
    end
    rx_ready = 1'b0;
    tick(2);
    check_eq("rx_credit_pulses", 32'(credit_pulses), 4);
    check_eq("rx_full_pop_accept", 32'(rx_data), 'hD005);
    check_eq("rx_left_valid", 32'(rx_valid), 1);

    // Reset mid-transfer with credit=2 and flits queued
    for (int i = 0; i < 2; i++) begin
      tx_valid = 1'b1;
      tx_dest = 8'h44;
      tx_payload = 8'(8'hE0 + i);
      tick(1);
    end
    tx_valid = 1'b0;
    tick(3);
    check_eq("pre_rst_credit", 32'(dut.credit_q), 2);
    tx_valid = 1'b1;
    tx_payload = 8'hE2;
    tick(1);
    tx_payload = 8'hE3;
    rst = 1'b0;
    n_sent = sent_q.size();
    tick(1);
    tx_valid = 1'b0;
    check_eq("mid_rst_tx_ready", 32'(tx_ready), 1);
    check_eq("mid_rst_net_valid", 32'(net_valid_o), 0);
    check_eq("mid_rst_credit", 32'(dut.credit_q), 4);
    check_eq("mid_rst_err", 32'(err_o), 0);
    check_eq("mid_rst_rx_valid", 32'(rx_valid), 0);
    check_eq("mid_rst_net_credit", 32'(net_credit_o), 0);
    rst = 1'b1;
    tick(4);
    check_eq("rst_discard", 32'(sent_q.size()), 32'(n_sent));

    // Statistics: four TX and three RX transfers
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1;
      tx_dest = 8'h56;
      tx_payload = 8'(8'hF0 + i);
      net_valid_i = (i < 3);
      net_data_i = 16'(16'h7700 + i);
      tick(1);
    end
    tx_valid = 1'b0;
    net_valid_i = 1'b0;
    tick(4);
    rx_ready = 1'b0;
    check_eq("stats_credit", 32'(dut.credit_q), 0);
`ifdef NET_IFACE_STATS_EN
    check_eq("stats_tx_count", 32'(tx_count_o), 4);
    check_eq("stats_rx_count", 32'(rx_count_o), 3);
`else
    check_eq("stats_tx_count", 32'(tx_count_o), 0);
    check_eq("stats_rx_count", 32'(rx_count_o), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
